// File: rtl/apb_master_ctrl.sv
// Single-outstanding command-to-APB master bridge (IDLE -> SETUP -> ACCESS).
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC PREADY-low cycles.
module apb_master_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        PSEL,
    output logic [17:0] PADDR,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("apb_master_ctrl: TIMEOUT_CYC must be within 1..255");
    end

    logic [1:0]    state_q,      state_d;
    logic          req_ready_q,  req_ready_d;
    logic          psel_q,       psel_d;
    logic          penable_q,    penable_d;
    logic [AW-1:0] paddr_q,      paddr_d;
    logic          pwrite_q,     pwrite_d;
    logic [DW-1:0] pwdata_q,     pwdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          resp_err_q,   resp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0]    TO_LAST       = 8'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d  = ST_SETUP;
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = pwrite_q ? '0 : PRDATA;
                    resp_err_d   = PSLVERR;
                end
`ifdef APB_TIMEOUT_EN
                // Last permitted wait cycle: give up and report an error
                else if (wait_cnt_q == TO_LAST) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = TIMEOUT_RDATA;
                    resp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        req_ready_d = (state_d == ST_IDLE);
`ifdef APB_TIMEOUT_EN
        if (state_d == ST_SETUP) begin
            wait_cnt_d = 8'd0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: directed commands, APB responder, response monitor.
`timescale 1ns/1ps
module tb_apb_master_ctrl;

    localparam int unsigned TO_CYC = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        PSEL;
    logic [17:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_master_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [17:0] addr;
        logic [31:0] pwdata;
        int          waits;
        logic [31:0] prdata;
        logic        pslverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          acc_cyc;
        int          resp_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // Monitor + APB responder, sampling on the falling edge
    initial begin : monitor
        int          acc_n;
        int          mon_acc;
        logic        prev_rv;
        logic [17:0] last_addr;
        logic        last_write;
        logic [31:0] last_wdata;
        logic [31:0] last_rdata;
        logic        last_err;
        exp_t        e;
        acc_n = 0; mon_acc = 0; prev_rv = 1'b0;
        last_addr = '0; last_write = 1'b0; last_wdata = '0; last_rdata = '0; last_err = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                acc_n = 0; mon_acc = 0; prev_rv = 1'b0;
                last_addr = '0; last_write = 1'b0; last_wdata = '0;
                last_rdata = '0; last_err = 1'b0;
                PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hBAD0_BAD0;
            end else begin
                if (resp_valid) begin
                    chk1("resp_one_cycle", prev_rv, 1'b0);
                    chk1("psel_at_resp", PSEL, 1'b0);
                    if (exp_q.size() == 0) begin
                        fail("unexpected_resp");
                    end else begin
                        e = exp_q.pop_front();
                        chk32("resp_rdata", resp_rdata, e.exp_rdata);
                        chk1("resp_err", resp_err, e.exp_err);
                        chk32("resp_cycle", 32'(cyc), 32'(e.resp_cyc));
                        chk32("access_cycles", 32'(mon_acc), 32'(e.acc_cyc));
                        last_rdata = e.exp_rdata;
                        last_err   = e.exp_err;
                    end
                end else begin
                    chk32("rdata_hold", resp_rdata, last_rdata);
                    chk1("err_hold", resp_err, last_err);
                end
                prev_rv = resp_valid;

                if (PSEL) begin
                    chk1("req_ready_busy", req_ready, 1'b0);
                    if (exp_q.size() == 0) begin
                        fail("psel_without_cmd");
                    end else begin
                        e = exp_q[0];
                        if (PENABLE) mon_acc++;
                        else         mon_acc = 0;
                        chk32("paddr", 32'(PADDR), 32'(e.addr));
                        chk1("pwrite", PWRITE, e.write);
                        chk32("pwdata", PWDATA, e.pwdata);
                        last_addr = e.addr; last_write = e.write; last_wdata = e.pwdata;
                    end
                end else begin
                    chk1("penable_idle", PENABLE, 1'b0);
                    chk32("paddr_hold", 32'(PADDR), 32'(last_addr));
                    chk1("pwrite_hold", PWRITE, last_write);
                    chk32("pwdata_hold", PWDATA, last_wdata);
                end

                // Responder: noisy PREADY/PSLVERR outside ACCESS must be ignored
                if (PSEL && PENABLE && exp_q.size() > 0) begin
                    e = exp_q[0];
                    PREADY  = (acc_n >= e.waits);
                    PRDATA  = PREADY ? e.prdata : 32'h0BAD_F00D;
                    PSLVERR = PREADY ? e.pslverr : 1'b1;
                    acc_n++;
                end else begin
                    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hBAD0_BAD0;
                    acc_n = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Present a command and push its expected response once accepted
    task automatic issue(input logic w, input logic [17:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] prd, input logic perr,
                         input logic [31:0] erd, input logic eerr, input int acc,
                         output int lat);
        exp_t e;
        lat = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && lat < 40) begin
            step(1);
            lat++;
        end
        if (!req_ready) begin
            fail("accept_timeout");
        end else begin
            e.write = w; e.addr = a; e.pwdata = w ? d : 32'h0;
            e.waits = waits; e.prdata = prd; e.pslverr = perr;
            e.exp_rdata = erd; e.exp_err = eerr; e.acc_cyc = acc;
            e.resp_cyc = cyc + 2 + acc;
            exp_q.push_back(e);
            step(1);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 60) begin
            step(1);
            b++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        int lat2;
        step(3);
        PRESET = 1'b0;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_psel", PSEL, 1'b0);
        chk1("rst_penable", PENABLE, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk32("rst_paddr", 32'(PADDR), 32'h0);
        chk32("rst_pwdata", PWDATA, 32'h0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk1("rst_resp_err", resp_err, 1'b0);
        step(2);

        // Zero-wait write: PSEL 2 cycles, resp at T+3
        issue(1'b1, 18'h4, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1, lat);
        chk32("w0_accept_lat", 32'(lat), 32'd0);
        req_valid = 1'b0;
        drain();

        // Read with 3 wait states: 4 ACCESS cycles
        issue(1'b0, 18'h8, 32'h7777_7777, 3, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 4, lat);
        req_valid = 1'b0;
        drain();

        // Back-to-back with req_valid held high
        issue(1'b1, 18'h10, 32'h1234_5678, 0, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 1, lat);
        issue(1'b0, 18'h11, 32'h9999_9999, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1, lat2);
        req_valid = 1'b0;
        chk32("b2b_first_lat", 32'(lat), 32'd0);
        chk32("b2b_second_lat", 32'(lat2), 32'd2);
        drain();

        // Read error and write error
        issue(1'b0, 18'h20, 32'h0, 1, 32'h55AA_33CC, 1'b1, 32'h55AA_33CC, 1'b1, 2, lat);
        req_valid = 1'b0;
        drain();
        issue(1'b1, 18'h3FFFF, 32'hFFFF_FFFF, 2, 32'h0000_1234, 1'b1, 32'h0, 1'b1, 3, lat);
        req_valid = 1'b0;
        drain();
        step(2);

        // Reset during ACCESS aborts without a response
        issue(1'b0, 18'h30, 32'h0, 20, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 21, lat);
        req_valid = 1'b0;
        step(1);
        chk1("pre_abort_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        exp_q.delete();
        step(1);
        PRESET = 1'b0;
        chk1("abort_psel", PSEL, 1'b0);
        chk1("abort_penable", PENABLE, 1'b0);
        chk1("abort_req_ready", req_ready, 1'b1);
        chk1("abort_resp_valid", resp_valid, 1'b0);
        step(6);

`ifdef APB_TIMEOUT_EN
        // Stuck PREADY: abort after TO_CYC wait cycles
        issue(1'b0, 18'h40, 32'h0, 1000, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 4, lat);
        req_valid = 1'b0;
        drain();
        issue(1'b1, 18'h41, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1, lat);
        req_valid = 1'b0;
        drain();
`else
        // Stuck PREADY: ACCESS waits indefinitely
        issue(1'b0, 18'h40, 32'h0, 1000, 32'h0, 1'b0, 32'h0, 1'b0, 1000, lat);
        req_valid = 1'b0;
        step(100);
        chk32("stuck_pending", 32'(exp_q.size()), 32'd1);
        chk1("stuck_psel", PSEL, 1'b1);
        chk1("stuck_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        exp_q.delete();
        step(1);
        PRESET = 1'b0;
        chk1("stuck_rst_ready", req_ready, 1'b1);
`endif
        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
